div_seq_32: RTL and testbench
=============================

Name: div_seq_32

Overview:
- Sequential unsigned restoring divider: dividend / divisor -> quotient, remainder. Division is the inverse use of the team's 32-bit carry-lookahead adder.
- Each iteration runs one trial subtraction through a single instance of CLA_32 in subtract mode: a = partial remainder, b = ~divisor, c_in = 1.
- Sits beside CLA_32 in the integer datapath. It is fed and drained by valid/ready handshakes.

Parameters:
- WIDTH, 32, operand/result width. Must match the CLA_32 instance; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept operands
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result was produced with divisor == 0

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (clk, rst_n).
- While rst_n = 0:
  - state = IDLE, in_ready = 0, out_valid = 0.
  - quotient = 0, remainder = 0, div_by_zero = 0, iteration counter = 0.
- First rising edge after rst_n deasserts: in_ready = 1.
- Reset asserted mid-operation aborts immediately. No result is produced and the state returns to IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - Accept occurs on a clock edge where in_valid & in_ready.
  - Accept with divisor != 0: latch dividend into the shift register Q, clear partial remainder R, latch divisor D, counter = 0. Go to RUN.
  - Accept with divisor == 0: quotient = all ones, remainder = dividend, div_by_zero = 1. Go to DONE. No RUN cycles.
- RUN (in_ready = 0), one iteration per cycle:
  - {t, R', Q'} = {R, Q} << 1, where t is the bit shifted out of R.
  - CLA_32 computes R' - D. Its c_out = 1 means no borrow.
  - If (t | c_out): R = CLA sum, Q[0] = 1.
  - Else: R = R', Q[0] = 0.
  - The CLA overflow output is unused.
  - Counter increments; after iteration WIDTH-1, go to DONE.
- DONE:
  - out_valid = 1 with quotient = Q, remainder = R, div_by_zero = 0 for the normal path.
  - Outputs hold stable while out_valid & !out_ready.
  - On out_valid & out_ready: out_valid = 0, in_ready = 1, go to IDLE. The outputs keep their last values.
- Latency:
  - Normal path: accept edge to out_valid high is WIDTH + 1 edges (33).
  - Divide-by-zero path: 1 edge.
- Throughput: no overlap; a new accept is only possible in IDLE. in_valid is ignored in RUN and DONE.
- Invariants:
  - For every non-zero divisor: quotient * divisor + remainder == dividend, and remainder < divisor.
  - div_by_zero is cleared on every accept and set only on the zero-divisor path.

Test Plan:
- Reset mid-RUN: accept 100 / 7, assert rst_n low at cycle 10 -> out_valid = 0 and in_ready = 0 asynchronously. After release, in_ready = 1 and no result appears.
- Basic: dividend = 100, divisor = 7 -> 33 edges after accept, out_valid = 1, quotient = 14, remainder = 2, div_by_zero = 0.
- Large operands exercising the shifted-out bit: dividend = 32'hFFFFFFFF, divisor = 32'h80000001 -> quotient = 1, remainder = 32'h7FFFFFFE.
  - Also dividend = 32'hFFFFFFFF, divisor = 1 -> quotient = 32'hFFFFFFFF, remainder = 0.
- Divide by zero: dividend = 32'h12345678, divisor = 0 -> out_valid on the next edge, quotient = 32'hFFFFFFFF, remainder = 32'h12345678, div_by_zero = 1.
  - A following 9 / 3 -> quotient = 3, remainder = 0, div_by_zero = 0.
- Backpressure: 50 / 8 with out_ready = 0 for 20 cycles -> quotient = 6 and remainder = 2 held stable, in_ready = 0 throughout, in_valid pulses ignored. out_ready = 1 -> one handshake, then IDLE.
- Random: 1000 random pairs with non-zero divisor and random out_ready -> quotient and remainder match the `/` and `%` operators, every result arrives at 33-edge latency, and no result is lost or duplicated.

Source files
------------

// File: rtl/div_seq_32.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Trial subtraction runs through the shared carry-lookahead adder.
module CLA_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out,
  output logic        overflow
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar i = 0; i < 8; i++) begin : grp
    localparam int B = 4 * i;
    assign c[B]   = gc[i];
    assign c[B+1] = g[B]
                  | (p[B] & gc[i]);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & gc[i]);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[i]);
    assign gg[i]  = g[B+3]
                  | (p[B+3] & g[B+2])
                  | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[i]  = &p[B+3:B];
  end

  // Block carries chained over the 4-bit group generate/propagate
  always_comb begin
    gc[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end

  assign sum      = p ^ c;
  assign c_out    = gc[8];
  assign overflow = c[31] ^ gc[8];

endmodule

module div_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             zero;
  logic             last;
  logic             t;
  logic             take;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] q_n;
  logic             c_out;
  logic             ovf_unused;

  assign accept = (state == IDLE) & in_valid & in_ready;
  assign zero   = (divisor == '0);
  assign last   = (cnt == CW'(WIDTH - 1));

  assign {t, r_sh, q_sh} = {r, q, 1'b0};

  CLA_32 u_cla (
    .a        (r_sh),
    .b        (~d),
    .c_in     (1'b1),
    .sum      (diff),
    .c_out    (c_out),
    .overflow (ovf_unused)
  );

  // A shifted-out bit means R' already exceeds any 32-bit divisor
  always_comb begin
    take = t | c_out;
    r_n  = take ? diff : r_sh;
    q_n  = {q_sh[WIDTH-1:1], take};
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = zero ? DONE : RUN;
      RUN:  if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      in_ready <= (state_n == IDLE);
      if (accept) begin
        if (zero) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          q           <= dividend;
          r           <= '0;
          d           <= divisor;
          cnt         <= '0;
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        q   <= q_n;
        r   <= r_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          quotient  <= q_n;
          remainder <= r_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_seq_32.sv
// Randomized bench for div_seq_32 against a plain arithmetic model.
// Latency counts the accept edge as edge 1.
module tb_div_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail = 0;

  div_seq_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit noisy);
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
    int          k;
    int          lat;
    bit          bad;
    ez = (b == 0);
    eq = ez ? 32'hFFFF_FFFF : a / b;
    er = ez ? a : a % b;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    chk("in_ready", {31'b0, in_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      if (noisy) begin
        in_valid = 1'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end
      tick();
      lat++;
    end
    chk($sformatf("latency %h/%h", a, b), lat, ez ? 32'd1 : 32'd33);
    chk($sformatf("quotient %h/%h", a, b), quotient, eq);
    chk($sformatf("remainder %h/%h", a, b), remainder, er);
    chk($sformatf("dbz %h/%h", a, b), {31'b0, div_by_zero}, {31'b0, ez});
    bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (noisy) begin
        in_valid = 1'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end
      tick();
      if (!out_valid || in_ready || quotient !== eq ||
          remainder !== er || div_by_zero !== ez) bad = 1'b1;
    end
    if (stall > 0) chk("hold", {31'b0, bad}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("in_ready_back", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    bit          seen;
    logic [31:0] a;
    logic [31:0] b;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("first_in_ready", {31'b0, in_ready}, 32'd1);

    dividend = 32'd100;
    divisor  = 32'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_in_ready_back", {31'b0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {31'b0, seen}, 32'd0);

    run_div(32'd100, 32'd7, 0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_div(32'h1234_5678, 32'd0, 0, 1'b0);
    run_div(32'd9, 32'd3, 0, 1'b0);
    run_div(32'd50, 32'd8, 20, 1'b1);
    tick();
    chk("idle_after_bp", {31'b0, out_valid}, 32'd0);

    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      if (n % 4 == 0) a = a >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if (b == 0) b = 32'd1;
      run_div(a, b, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
